// File: rtl/vldrdy_join_n.sv
// N-channel valid/ready join: per-channel FIFOs feed one registered, lock-step output beat.
// Optional synchronous flush port is enabled by defining VLDRDY_JOIN_FLUSH_EN.
module vldrdy_join_n #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_valid,
  output logic [NCH-1:0]    i_ready,
  input  logic [NCH*DW-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NCH*DW-1:0] o_data
`ifdef VLDRDY_JOIN_FLUSH_EN
  ,
  input  logic              i_flush
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0]     mem    [NCH][DEPTH];
  logic [PW-1:0]     wr_ptr [NCH];
  logic [PW-1:0]     rd_ptr [NCH];
  logic [PW-1:0]     wr_nxt [NCH];
  logic [PW-1:0]     rd_nxt [NCH];
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    full_nxt;
  logic [NCH*DW-1:0] head;
  logic              all_avail;
  logic              pop;
  logic              flush;

`ifdef VLDRDY_JOIN_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Join decision and next-pointer state; i_ready is derived from next-cycle fullness.
  always_comb begin
    all_avail = 1'b1;
    push      = '0;
    empty     = '0;
    full_nxt  = '0;
    head      = '0;
    for (int k = 0; k < NCH; k++) begin
      empty[k] = (wr_ptr[k] == rd_ptr[k]);
      if (empty[k]) all_avail = 1'b0;
      push[k] = i_valid[k] & i_ready[k];
      head[k*DW +: DW] = mem[k][rd_ptr[k][AW-1:0]];
    end
    pop = all_avail & (~o_valid | o_ready);
    for (int k = 0; k < NCH; k++) begin
      wr_nxt[k]   = wr_ptr[k] + PW'(push[k]);
      rd_nxt[k]   = rd_ptr[k] + PW'(pop);
      full_nxt[k] = (wr_nxt[k][PW-1] != rd_nxt[k][PW-1]) &&
                    (wr_nxt[k][AW-1:0] == rd_nxt[k][AW-1:0]);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (push[k] && !flush) mem[k][wr_ptr[k][AW-1:0]] <= i_data[k*DW +: DW];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      i_ready <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (flush) begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      i_ready <= '1;
      o_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr[k]  <= wr_nxt[k];
        rd_ptr[k]  <= rd_nxt[k];
        i_ready[k] <= ~full_nxt[k];
      end
      if (pop) begin
        o_valid <= 1'b1;
        o_data  <= head;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vldrdy_join_n.sv
// Self-checking bench for vldrdy_join_n: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vldrdy_join_n;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned W     = NCH * DW;
  localparam int unsigned NVEC  = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] vld;
  logic [NCH-1:0] rdy;
  logic [W-1:0]   din;
  logic [W-1:0]   dout;
  logic           ov;
  logic           ordy;
  logic           flush;

  logic [2:0]     vld3;
  logic [2:0]     rdy3;
  logic [11:0]    din3;
  logic [11:0]    dout3;
  logic           ov3;
  logic           ordy3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vldrdy_join_n #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_ready(rdy), .i_data(din),
    .o_valid(ov), .o_ready(ordy), .o_data(dout)
`ifdef VLDRDY_JOIN_FLUSH_EN
    , .i_flush(flush)
`endif
  );

  vldrdy_join_n #(.NCH(3), .DW(4), .DEPTH(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld3), .i_ready(rdy3), .i_data(din3),
    .o_valid(ov3), .o_ready(ordy3), .o_data(dout3)
`ifdef VLDRDY_JOIN_FLUSH_EN
    , .i_flush(flush)
`endif
  );

  // Reference model: one queue per channel plus the output register.
  logic [DW-1:0]  mq [NCH][$];
  logic           m_ov;
  logic [W-1:0]   m_od;
  logic [NCH-1:0] m_rdy;

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) mq[k].delete();
    m_ov  = 1'b0;
    m_od  = '0;
    m_rdy = '0;
  endfunction

  function automatic void model_flush();
    for (int k = 0; k < NCH; k++) mq[k].delete();
    m_ov  = 1'b0;
    m_rdy = '1;
  endfunction

  function automatic void model_edge(input logic [NCH-1:0] v, input logic [W-1:0] d, input logic r);
    logic [NCH-1:0] acc;
    logic           take;
    acc  = v & m_rdy;
    take = !m_ov || r;
    for (int k = 0; k < NCH; k++) if (mq[k].size() == 0) take = 1'b0;
    if (take) begin
      for (int k = 0; k < NCH; k++) m_od[k*DW +: DW] = mq[k].pop_front();
      m_ov = 1'b1;
    end else if (r) begin
      m_ov = 1'b0;
    end
    for (int k = 0; k < NCH; k++) if (acc[k]) mq[k].push_back(d[k*DW +: DW]);
    for (int k = 0; k < NCH; k++) m_rdy[k] = (mq[k].size() < DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_rdy",  32'(rdy),  32'(m_rdy));
    check("model_ov",   32'(ov),   32'(m_ov));
    check("model_data", 32'(dout), 32'(m_od));
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    check_model();
    vld  = v;
    din  = d;
    ordy = r;
    @(posedge clk);
    model_edge(v, d, r);
  endtask

  typedef struct {
    logic [NCH-1:0] v;
    logic [W-1:0]   d;
    logic           r;
    logic [NCH-1:0] e_rdy;
    logic           e_ov;
    logic [W-1:0]   e_od;
  } vec_t;

  vec_t           tbl [NVEC];
  int             sent [NCH];
  int             got;
  logic [NCH-1:0] bp_v;
  logic [W-1:0]   bp_d;
  logic           bp_r;
  int             n_sent;
  int             n_got;
  int             first_c;
  int             last_c;

  initial begin
    // aligned single beat, then ch0-early skew
    tbl[0]  = '{2'b11, 16'h3CA5, 1'b1, 2'b11, 1'b0, 16'h0000};
    tbl[1]  = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b0, 16'h0000};
    tbl[2]  = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b1, 16'h3CA5};
    tbl[3]  = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b0, 16'h3CA5};
    tbl[4]  = '{2'b01, 16'h0001, 1'b1, 2'b11, 1'b0, 16'h3CA5};
    tbl[5]  = '{2'b01, 16'h0002, 1'b1, 2'b11, 1'b0, 16'h3CA5};
    tbl[6]  = '{2'b00, 16'h0000, 1'b1, 2'b10, 1'b0, 16'h3CA5};
    tbl[7]  = '{2'b00, 16'h0000, 1'b1, 2'b10, 1'b0, 16'h3CA5};
    tbl[8]  = '{2'b00, 16'h0000, 1'b1, 2'b10, 1'b0, 16'h3CA5};
    tbl[9]  = '{2'b10, 16'h1100, 1'b1, 2'b10, 1'b0, 16'h3CA5};
    tbl[10] = '{2'b10, 16'h1200, 1'b1, 2'b10, 1'b0, 16'h3CA5};
    tbl[11] = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b1, 16'h1101};
    tbl[12] = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b1, 16'h1202};
    tbl[13] = '{2'b00, 16'h0000, 1'b1, 2'b11, 1'b0, 16'h1202};

    vld = '0; din = '0; ordy = 1'b0; flush = 1'b0;
    vld3 = '0; din3 = '0; ordy3 = 1'b0;
    model_reset();

    // reset held for three cycles
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_rdy",  32'(rdy),  32'(0));
      check("rst_ov",   32'(ov),   32'(0));
      check("rst_data", 32'(dout), 32'(0));
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_edge('0, '0, 1'b0);

    // directed vectors
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_rdy", i),  32'(rdy),  32'(tbl[i].e_rdy));
      check($sformatf("vec%0d_ov", i),   32'(ov),   32'(tbl[i].e_ov));
      check($sformatf("vec%0d_data", i), 32'(dout), 32'(tbl[i].e_od));
      vld = tbl[i].v; din = tbl[i].d; ordy = tbl[i].r;
      @(posedge clk);
      model_edge(tbl[i].v, tbl[i].d, tbl[i].r);
    end

    // backpressure: 4 beats per channel, o_ready low for the first 6 cycles
    for (int k = 0; k < NCH; k++) sent[k] = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      check_model();
      bp_r = (cyc >= 6);
      if (cyc == 3) check("bp_rdy_drop", 32'(rdy), 32'(0));
      if (ov) begin
        check(bp_r ? "bp_order" : "bp_hold", 32'(dout),
              32'({8'(8'h50 + got), 8'(8'h40 + got)}));
        if (bp_r) got++;
      end
      for (int k = 0; k < NCH; k++) bp_v[k] = (sent[k] < 4);
      bp_d = {8'(8'h50 + sent[1]), 8'(8'h40 + sent[0])};
      vld = bp_v; din = bp_d; ordy = bp_r;
      @(posedge clk);
      for (int k = 0; k < NCH; k++) if (bp_v[k] && m_rdy[k]) sent[k]++;
      model_edge(bp_v, bp_d, bp_r);
    end
    check("bp_count", 32'(got), 32'(4));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(NCH'($urandom), W'($urandom),
           (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset in mid-operation
    step(2'b11, 16'hBEEF, 1'b0);
    step(2'b11, 16'hCAFE, 1'b0);
    step(2'b00, 16'h0000, 1'b0);
    @(negedge clk);
    check_model();
    check("pre_rst_ov", 32'(ov), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ov",   32'(ov),   32'(0));
    check("async_rst_rdy",  32'(rdy),  32'(0));
    check("async_rst_data", 32'(dout), 32'(0));
    vld = '0; ordy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_edge('0, '0, 1'b0);
    step(2'b11, 16'h7788, 1'b1);
    step(2'b00, 16'h0000, 1'b1);
    step(2'b00, 16'h0000, 1'b1);
    step(2'b00, 16'h0000, 1'b1);

`ifdef VLDRDY_JOIN_FLUSH_EN
    // flush discards two beats buffered on ch0
    step(2'b01, 16'h00AA, 1'b1);
    step(2'b01, 16'h00BB, 1'b1);
    @(negedge clk);
    check_model();
    flush = 1'b1; vld = '0; ordy = 1'b1;
    @(posedge clk);
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    check("flush_ov",  32'(ov),  32'(0));
    check("flush_rdy", 32'(rdy), 32'(2'b11));
    @(posedge clk);
    model_edge('0, '0, 1'b1);
    step(2'b11, 16'h2211, 1'b1);
    step(2'b00, 16'h0000, 1'b1);
    step(2'b00, 16'h0000, 1'b1);
    step(2'b00, 16'h0000, 1'b1);
`endif

    // full throughput on the 3-channel instance
    n_sent = 0; n_got = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ov3) begin
        check("tp_data", 32'(dout3), 32'({3{4'(n_got)}}));
        n_got++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if (n_sent < 16) begin
        check("tp_rdy", 32'(rdy3), 32'(3'b111));
        vld3 = 3'b111;
        din3 = {3{4'(n_sent)}};
      end else begin
        vld3 = 3'b000;
      end
      ordy3 = 1'b1;
      @(posedge clk);
      if (vld3 != 3'b000) n_sent++;
    end
    check("tp_count", 32'(n_got), 32'(16));
    check("tp_span",  32'(last_c - first_c + 1), 32'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
